// File: rtl/button_event_ctrl_if.sv
// Event stream from the button controller to the application FSM.
// A transfer happens on a clock edge where evt_valid and evt_ready are both high.
interface button_event_ctrl_if #(
  parameter int ID_W = 2
) ();
  logic            evt_valid;
  logic            evt_ready;
  logic [ID_W-1:0] evt_id;
  logic [1:0]      evt_kind;

  modport master (output evt_valid, output evt_id, output evt_kind, input evt_ready);
  modport slave  (input evt_valid, input evt_id, input evt_kind, output evt_ready);
endinterface

// File: rtl/button_event_ctrl.sv
// Turns debounced button levels into PRESS/SHORT/LONG/REPEAT events.
// Each button has a hold-time FSM and a one-deep pending slot; a round-robin arbiter feeds one output stream.
module button_event_ctrl #(
  parameter int N_BTN      = 4,
  parameter int ID_W       = 2,
  parameter int LONG_CYC   = 50000000,
  parameter int REPEAT_CYC = 10000000,
  parameter int CNT_W      = 26
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [N_BTN-1:0]   btn,
  output logic [N_BTN-1:0]   held,
  output logic [7:0]         drop_cnt,
  button_event_ctrl_if.master evt
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HELD,
    ST_LONG
  } state_t;

  localparam logic [1:0] KIND_PRESS  = 2'd0;
  localparam logic [1:0] KIND_SHORT  = 2'd1;
  localparam logic [1:0] KIND_LONG   = 2'd2;
  localparam logic [1:0] KIND_REPEAT = 2'd3;

  logic [N_BTN-1:0] btn_q_reg;
  logic [N_BTN-1:0] rise;
  logic [N_BTN-1:0] fall;
  logic [N_BTN-1:0] emit;
  logic [1:0]       emit_kind [N_BTN];
  logic [N_BTN-1:0] full;
  logic [1:0]       slot_kind [N_BTN];
  logic [N_BTN-1:0] dropped;

  logic [N_BTN-1:0] grant;
  logic             grant_any;
  logic [ID_W-1:0]  grant_idx;
  logic [1:0]       grant_kind;
  logic [ID_W-1:0]  rr_next;
  logic             load;

  logic             valid_reg;
  logic [ID_W-1:0]  id_reg;
  logic [1:0]       kind_reg;
  logic [ID_W-1:0]  rr_reg;
  logic [7:0]       drop_reg;
  logic [8:0]       drop_sum;

  assign rise = btn & ~btn_q_reg;
  assign fall = ~btn & btn_q_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) btn_q_reg <= '0;
    else       btn_q_reg <= btn;
  end

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             emit_reg;
    logic [1:0]       emit_kind_reg;
    logic             full_reg;
    logic [1:0]       slot_kind_reg;

    // Hold-time FSM; its event output is registered, so the slot sees it one cycle later.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        state_reg     <= ST_IDLE;
        cnt_reg       <= '0;
        emit_reg      <= 1'b0;
        emit_kind_reg <= KIND_PRESS;
      end else begin
        emit_reg <= 1'b0;
        case (state_reg)
          ST_IDLE: begin
            if (rise[gi]) begin
              emit_reg      <= 1'b1;
              emit_kind_reg <= KIND_PRESS;
              cnt_reg       <= '0;
              state_reg     <= ST_HELD;
            end
          end
          ST_HELD: begin
            if (fall[gi]) begin
              emit_reg      <= 1'b1;
              emit_kind_reg <= KIND_SHORT;
              state_reg     <= ST_IDLE;
            end else if (cnt_reg == CNT_W'(LONG_CYC - 1)) begin
              emit_reg      <= 1'b1;
              emit_kind_reg <= KIND_LONG;
              cnt_reg       <= '0;
              state_reg     <= ST_LONG;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
          ST_LONG: begin
            if (fall[gi]) begin
              state_reg <= ST_IDLE;
            end else if (cnt_reg == CNT_W'(REPEAT_CYC - 1)) begin
              emit_reg      <= 1'b1;
              emit_kind_reg <= KIND_REPEAT;
              cnt_reg       <= '0;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end

    // A grant in the same cycle frees the slot for the incoming event.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        full_reg      <= 1'b0;
        slot_kind_reg <= KIND_PRESS;
      end else if (emit_reg && (!full_reg || grant[gi])) begin
        full_reg      <= 1'b1;
        slot_kind_reg <= emit_kind_reg;
      end else if (grant[gi]) begin
        full_reg <= 1'b0;
      end
    end

    assign emit[gi]      = emit_reg;
    assign emit_kind[gi] = emit_kind_reg;
    assign full[gi]      = full_reg;
    assign slot_kind[gi] = slot_kind_reg;
    assign dropped[gi]   = emit_reg & full_reg & ~grant[gi];
  end

  assign load = !valid_reg || evt.evt_ready;

  // Round-robin search: first full slot at or after rr_reg, wrapping around.
  always_comb begin
    int idx;
    grant      = '0;
    grant_any  = 1'b0;
    grant_idx  = '0;
    grant_kind = KIND_PRESS;
    for (int k = 0; k < N_BTN; k++) begin
      idx = int'(rr_reg) + k;
      if (idx >= N_BTN) idx = idx - N_BTN;
      for (int j = 0; j < N_BTN; j++) begin
        if (j == idx && full[j] && !grant_any) begin
          grant_any  = 1'b1;
          grant_idx  = ID_W'(j);
          grant_kind = slot_kind[j];
        end
      end
    end
    for (int j = 0; j < N_BTN; j++) begin
      if (load && grant_any && grant_idx == ID_W'(j)) grant[j] = 1'b1;
    end
    rr_next = (grant_idx == ID_W'(N_BTN - 1)) ? '0 : grant_idx + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_reg <= 1'b0;
      id_reg    <= '0;
      kind_reg  <= KIND_PRESS;
      rr_reg    <= '0;
    end else if (load) begin
      if (grant_any) begin
        valid_reg <= 1'b1;
        id_reg    <= grant_idx;
        kind_reg  <= grant_kind;
        rr_reg    <= rr_next;
      end else begin
        valid_reg <= 1'b0;
      end
    end
  end

  // Several buttons can lose an event in the same cycle.
  assign drop_sum = {1'b0, drop_reg} + 9'($countones(dropped));

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                drop_reg <= '0;
    else if (drop_sum > 9'd255) drop_reg <= 8'd255;
    else                      drop_reg <= drop_sum[7:0];
  end

  assign held          = btn_q_reg;
  assign drop_cnt      = drop_reg;
  assign evt.evt_valid = valid_reg;
  assign evt.evt_id    = id_reg;
  assign evt.evt_kind  = kind_reg;

endmodule

// File: tb/tb_button_event_ctrl.sv
// Bench for button_event_ctrl: directed scenarios plus random stimulus, each cycle checked
// against an age-based event model with a depth-1 slot and round-robin output stage.
module tb_button_event_ctrl;
  localparam int N      = 4;
  localparam int ID_W   = 2;
  localparam int LONG   = 60;
  localparam int REP    = 20;
  localparam int CNT_W  = 8;
  localparam int OW     = N + 8 + 1 + ID_W + 2;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] btn   = '0;
  logic [N-1:0] held;
  logic [7:0]   drop_cnt;

  button_event_ctrl_if #(.ID_W(ID_W)) ev ();

  button_event_ctrl #(
    .N_BTN(N), .ID_W(ID_W), .LONG_CYC(LONG), .REPEAT_CYC(REP), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .reset(reset), .btn(btn), .held(held), .drop_cnt(drop_cnt), .evt(ev)
  );

  always #5 clock = ~clock;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Reference model state
  logic [N-1:0]    m_prev;
  logic [N-1:0]    m_full;
  logic [N-1:0]    m_inc;
  logic [1:0]      m_skind [N];
  logic [1:0]      m_inck  [N];
  int              m_age   [N];
  logic            m_valid;
  logic [ID_W-1:0] m_id;
  logic [1:0]      m_kind;
  int              m_rr;
  int              m_drop;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [1:0]      kind;
    int              cyc;
  } xfer_t;
  xfer_t xq[$];

  function automatic logic [OW-1:0] obs();
    return {held, drop_cnt, ev.evt_valid,
            ev.evt_valid ? ev.evt_id : {ID_W{1'b0}},
            ev.evt_valid ? ev.evt_kind : 2'b00};
  endfunction

  function automatic logic [OW-1:0] exp_obs();
    return {m_prev, 8'(m_drop), m_valid,
            m_valid ? m_id : {ID_W{1'b0}},
            m_valid ? m_kind : 2'b00};
  endfunction

  task automatic model_reset();
    m_prev = '0; m_full = '0; m_inc = '0;
    m_valid = 1'b0; m_id = '0; m_kind = '0; m_rr = 0; m_drop = 0;
    for (int i = 0; i < N; i++) begin
      m_skind[i] = '0; m_inck[i] = '0; m_age[i] = 0;
    end
  endtask

  task automatic model_edge(input logic [N-1:0] b, input logic r);
    bit found;
    int g;
    // output stage picks from slots as they stood before this edge
    if (!m_valid || r) begin
      found = 0; g = 0;
      for (int k = 0; k < N; k++) begin
        if (!found && m_full[(m_rr + k) % N]) begin
          found = 1; g = (m_rr + k) % N;
        end
      end
      if (found) begin
        m_valid = 1'b1; m_id = ID_W'(g); m_kind = m_skind[g];
        m_full[g] = 1'b0; m_rr = (g + 1) % N;
      end else begin
        m_valid = 1'b0;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (m_inc[i]) begin
        if (!m_full[i]) begin
          m_full[i] = 1'b1; m_skind[i] = m_inck[i];
        end else if (m_drop < 255) begin
          m_drop++;
        end
      end
    end
    // events from level history: age counts edges since the press
    for (int i = 0; i < N; i++) begin
      m_inc[i] = 1'b0;
      if (b[i] && !m_prev[i]) begin
        m_inc[i] = 1'b1; m_inck[i] = 2'd0; m_age[i] = 0;
      end else if (b[i]) begin
        m_age[i]++;
        if (m_age[i] == LONG) begin
          m_inc[i] = 1'b1; m_inck[i] = 2'd2;
        end else if (m_age[i] > LONG && (m_age[i] - LONG) % REP == 0) begin
          m_inc[i] = 1'b1; m_inck[i] = 2'd3;
        end
      end else if (m_prev[i] && m_age[i] < LONG) begin
        m_inc[i] = 1'b1; m_inck[i] = 2'd1;
      end
    end
    m_prev = b;
  endtask

  task automatic step();
    if (ev.evt_valid && ev.evt_ready && !reset)
      xq.push_back('{id: ev.evt_id, kind: ev.evt_kind, cyc: cyc});
    @(posedge clock);
    if (reset) model_reset();
    else       model_edge(btn, ev.evt_ready);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    btn = '0; ev.evt_ready = 1'b0; reset = 1'b1;
    model_reset();
    step(); step();
    reset = 1'b0;
    xq.delete();
  endtask

  task automatic test_reset();
    btn = 4'hF; ev.evt_ready = 1'b1;
    repeat (5) step();
    reset = 1'b1; #1;
    n_cmp++;
    if ({ev.evt_valid, ev.evt_id, ev.evt_kind, held, drop_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%0b id=%0d kind=%0d held=%h drop=%0d required all 0",
               ev.evt_valid, ev.evt_id, ev.evt_kind, held, drop_cnt);
    end
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(); n_cmp++;
      if (obs() !== exp_obs()) begin
        n_fail++; $display("FAIL reset_idle cyc=%0d: got %h required %h", cyc, obs(), exp_obs());
      end
    end
  endtask

  task automatic test_short();
    do_reset(); ev.evt_ready = 1'b1; btn = 4'b0010;
    for (int i = 0; i < 40; i++) begin
      if (i == 30) btn = '0;
      step(); n_cmp++;
      if (obs() !== exp_obs()) begin
        n_fail++; $display("FAIL short_model cyc=%0d: got %h required %h", cyc, obs(), exp_obs());
      end
    end
    n_cmp++;
    if (xq.size() != 2 || xq[0].id !== 2'd1 || xq[0].kind !== 2'd0 ||
        xq[1].id !== 2'd1 || xq[1].kind !== 2'd1 || xq[1].cyc - xq[0].cyc != 30) begin
      n_fail++; $display("FAIL short_seq: got %0d transfers required PRESS/SHORT on id 1, 30 apart", xq.size());
    end
    n_cmp++;
    if (drop_cnt !== 8'd0) begin
      n_fail++; $display("FAIL short_drop: got %0d required 0", drop_cnt);
    end
  endtask

  task automatic test_long();
    logic [1:0] kinds [5];
    int         offs  [5];
    kinds = '{2'd0, 2'd2, 2'd3, 2'd3, 2'd3};
    offs  = '{0, LONG, LONG + REP, LONG + 2 * REP, LONG + 3 * REP};
    do_reset(); ev.evt_ready = 1'b1; btn = 4'b0001;
    for (int i = 0; i < LONG + 3 * REP + 10 + 12; i++) begin
      if (i == LONG + 3 * REP + 10) btn = '0;
      step(); n_cmp++;
      if (obs() !== exp_obs()) begin
        n_fail++; $display("FAIL long_model cyc=%0d: got %h required %h", cyc, obs(), exp_obs());
      end
    end
    n_cmp++;
    if (xq.size() != 5) begin
      n_fail++; $display("FAIL long_count: got %0d transfers required 5", xq.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        n_cmp++;
        if (xq[k].id !== 2'd0 || xq[k].kind !== kinds[k] || xq[k].cyc - xq[0].cyc != offs[k]) begin
          n_fail++;
          $display("FAIL long_evt%0d: got id=%0d kind=%0d at +%0d required id=0 kind=%0d at +%0d",
                   k, xq[k].id, xq[k].kind, xq[k].cyc - xq[0].cyc, kinds[k], offs[k]);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    do_reset(); ev.evt_ready = 1'b1; btn = 4'hF;
    for (int i = 0; i < 16; i++) begin
      if (i == 8) btn = '0;
      step(); n_cmp++;
      if (obs() !== exp_obs()) begin
        n_fail++; $display("FAIL rr_model cyc=%0d: got %h required %h", cyc, obs(), exp_obs());
      end
    end
    n_cmp++;
    if (xq.size() != 8) begin
      n_fail++; $display("FAIL rr_count: got %0d transfers required 8", xq.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        n_cmp++;
        if (xq[k].id !== ID_W'(k % 4) || xq[k].kind !== ((k < 4) ? 2'd0 : 2'd1) ||
            (k % 4 != 0 && xq[k].cyc != xq[k - 1].cyc + 1)) begin
          n_fail++; $display("FAIL rr_order%0d: got id=%0d kind=%0d required id=%0d back-to-back",
                             k, xq[k].id, xq[k].kind, k % 4);
        end
      end
    end
    xq.delete();
    btn = 4'b0010;
    repeat (6) step();
    btn = 4'b1011;
    for (int i = 0; i < 6; i++) begin
      step(); n_cmp++;
      if (obs() !== exp_obs()) begin
        n_fail++; $display("FAIL rr_wrap_model cyc=%0d: got %h required %h", cyc, obs(), exp_obs());
      end
    end
    n_cmp++;
    if (xq.size() != 3 || xq[0].id !== 2'd1 || xq[1].id !== 2'd3 || xq[2].id !== 2'd0) begin
      n_fail++; $display("FAIL rr_wrap: got %0d transfers (ids %0d,%0d,%0d) required ids 1,3,0",
                         xq.size(), xq[0].id, xq[1].id, xq[2].id);
    end
  endtask

  task automatic test_stall();
    do_reset(); ev.evt_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      btn = ((i / 4) % 2 == 0) ? 4'b0100 : 4'b0000;
      step(); n_cmp++;
      if (obs() !== exp_obs()) begin
        n_fail++; $display("FAIL stall_model cyc=%0d: got %h required %h", cyc, obs(), exp_obs());
      end
      if (i >= 2) begin
        n_cmp++;
        if (ev.evt_valid !== 1'b1 || ev.evt_id !== 2'd2 || ev.evt_kind !== 2'd0) begin
          n_fail++; $display("FAIL stall_hold cyc=%0d: got valid=%0b id=%0d kind=%0d required 1/2/0",
                             cyc, ev.evt_valid, ev.evt_id, ev.evt_kind);
        end
      end
    end
    n_cmp++;
    if (drop_cnt !== 8'd2) begin
      n_fail++; $display("FAIL stall_drop: got %0d required 2", drop_cnt);
    end
    ev.evt_ready = 1'b1;
    repeat (6) step();
    n_cmp++;
    if (xq.size() != 2 || xq[0].id !== 2'd2 || xq[0].kind !== 2'd0 ||
        xq[1].id !== 2'd2 || xq[1].kind !== 2'd1 || ev.evt_valid !== 1'b0) begin
      n_fail++; $display("FAIL stall_drain: got %0d transfers valid=%0b required PRESS,SHORT on id 2 then idle",
                         xq.size(), ev.evt_valid);
    end
  endtask

  task automatic test_reset_mid();
    do_reset(); ev.evt_ready = 1'b0; btn = 4'b0001;
    repeat (10) step();
    n_cmp++;
    if (ev.evt_valid !== 1'b1) begin
      n_fail++; $display("FAIL rmid_pre: got valid=%0b required 1", ev.evt_valid);
    end
    reset = 1'b1; #1;
    n_cmp++;
    if (ev.evt_valid !== 1'b0) begin
      n_fail++; $display("FAIL rmid_async: got valid=%0b required 0", ev.evt_valid);
    end
    step(); step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); n_cmp++;
      if (ev.evt_valid !== (i == 2) || (i == 2 && (ev.evt_id !== 2'd0 || ev.evt_kind !== 2'd0))) begin
        n_fail++; $display("FAIL rmid_press +%0d: got valid=%0b id=%0d kind=%0d required valid=%0b id=0 kind=0",
                           i + 1, ev.evt_valid, ev.evt_id, ev.evt_kind, i == 2);
      end
      n_cmp++;
      if (obs() !== exp_obs()) begin
        n_fail++; $display("FAIL rmid_model cyc=%0d: got %h required %h", cyc, obs(), exp_obs());
      end
    end
  endtask

  task automatic test_saturate();
    do_reset(); ev.evt_ready = 1'b0;
    for (int p = 0; p < 320; p++) begin
      btn = 4'b0001; step();
      btn = 4'b0000; step();
      n_cmp++;
      if (obs() !== exp_obs()) begin
        n_fail++; $display("FAIL sat_model cyc=%0d: got %h required %h", cyc, obs(), exp_obs());
      end
    end
    repeat (3) step();
    n_cmp++;
    if (drop_cnt !== 8'd255) begin
      n_fail++; $display("FAIL sat_drop: got %0d required 255", drop_cnt);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 49) == 0) btn[b] = ~btn[b];
      if ((i / 150) % 4 == 3) ev.evt_ready = 1'b0;
      else                    ev.evt_ready = ($urandom_range(0, 3) != 0);
      step(); n_cmp++;
      if (obs() !== exp_obs()) begin
        n_fail++; $display("FAIL random_model cyc=%0d: got %h required %h", cyc, obs(), exp_obs());
      end
    end
  endtask

  initial begin
    ev.evt_ready = 1'b0;
    model_reset();
    #2;
    do_reset();
    test_reset();
    test_short();
    test_long();
    test_round_robin();
    test_stall();
    test_reset_mid();
    test_saturate();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/button_event_ctrl.md
Name: button_event_ctrl

Overview:
- Sits downstream of one debouncer instance per push-button and turns the clean button levels into discrete UI events: PRESS, SHORT, LONG and REPEAT.
- Each button has its own hold-time state machine and a one-deep pending slot.
- A round-robin arbiter feeds all buttons into a single valid/ready event stream for the application FSM.
- Dropped events are counted for debug.

Parameters:
- N_BTN, 4, number of buttons (2..8).
- ID_W, 2, width of evt_id; must be ≥ clog2(N_BTN).
- LONG_CYC, 50000000, cycles a button must stay held before LONG fires (0.5 s at 100 MHz); must be ≥ 2.
- REPEAT_CYC, 10000000, cycles between successive REPEAT events while held after LONG; must be ≥ 2.
- CNT_W, 26, hold-counter width; must satisfy 2^CNT_W > max(LONG_CYC, REPEAT_CYC).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- btn  in  N_BTN  debounced button levels, 1 = pressed, synchronous to clock.
- evt_valid  out  1  event available.
- evt_ready  in  1  consumer accepts; a transfer occurs when evt_valid & evt_ready.
- evt_id  out  ID_W  index of the button that produced the event.
- evt_kind  out  2  0 = PRESS, 1 = SHORT, 2 = LONG, 3 = REPEAT.
- held  out  N_BTN  registered copy of btn (btn_q).
- drop_cnt  out  8  saturating count of events lost to a full pending slot.

Behaviour:
- Reset (asynchronous, active-high): clears all state.
  - Outputs: evt_valid=0, evt_id=0, evt_kind=0, held=0, drop_cnt=0.
  - Internal: all FSMs return to IDLE, counters=0, pending slots empty, RR pointer=0.
  - Reset mid-operation discards everything in flight, including a valid-but-unaccepted event.
- Edge detection: btn_q <= btn every cycle.
  - rise = btn & ~btn_q; fall = ~btn & btn_q.
  - A button already high when reset deasserts produces a PRESS.
- Per-button FSM (states IDLE, HELD, LONG_HELD), evaluated every cycle:
  - IDLE: on rise, emit PRESS, cnt=0, go to HELD.
  - HELD, fall: emit SHORT, go to IDLE.
  - HELD, cnt == LONG_CYC-1: emit LONG, cnt=0, go to LONG_HELD.
  - HELD, otherwise: cnt+1.
  - LONG_HELD, fall: no event, go to IDLE.
  - LONG_HELD, cnt == REPEAT_CYC-1: emit REPEAT, cnt=0.
  - LONG_HELD, otherwise: cnt+1.
  - Timing: LONG fires LONG_CYC cycles after PRESS. REPEATs follow every REPEAT_CYC cycles after LONG.
- Pending slot (one per button, holding {full, kind}):
  - An emitted event is written into the slot if it is empty, or if it is freed by a grant in the same cycle (the grant takes the old event and the slot takes the new one).
  - Otherwise the new event is dropped and drop_cnt increments, saturating at 255. The old pending event is kept.
- Output register: loads when evt_valid=0, or when evt_valid & evt_ready (back-to-back transfers are allowed, one event per cycle).
  - On load, the grant goes to the first full slot found by searching from rr_ptr upward with wrap-around.
  - That slot is cleared, evt_id and evt_kind are set, evt_valid=1, and rr_ptr = granted index + 1 (mod N_BTN).
  - No full slot: evt_valid=0 after a completed transfer.
- Handshake: while evt_valid=1 and evt_ready=0, evt_id and evt_kind stay stable and evt_valid stays high.
- Latency: rise on btn at clock edge t gives pending at t+1 and evt_valid at t+2, provided the output is free.

Test Plan:
- Hold btn[1] for 100 cycles with LONG_CYC=1000, evt_ready=1 → PRESS (id 1, kind 0), then SHORT (id 1, kind 1) 2 cycles after release; no LONG; drop_cnt=0.
- Hold btn[0] for 1000+3*200+50 cycles with LONG_CYC=1000, REPEAT_CYC=200 → exactly PRESS, LONG at +1000, REPEAT at +1200, +1400, +1600; no event on release.
- Raise btn[3:0] in the same cycle with evt_ready=1 → 4 PRESS events on consecutive cycles with ids 0, 1, 2, 3. Raise all again after release → next id order continues from rr_ptr.
- Hold evt_ready=0 while btn[2] is pressed, released and pressed again (slot full) → evt_valid stays high with id 2/PRESS stable; second PRESS replaces nothing; drop_cnt increments by 1 for each dropped event; releasing evt_ready drains the remaining events in order.
- Assert reset while btn[0] is in HELD with evt_valid=1 → evt_valid drops immediately; after reset releases with btn[0] still high, a new PRESS appears at +2 cycles.
- Drive 300 dropped events (evt_ready=0, short pulses) → drop_cnt saturates at 255.
